matrix_led_scanner: RTL and testbench

MATRIX_LED_SCANNER -- requirements
Module: matrix_led_scanner

---
 rtl/matrix_led_pkg.sv | 18 +
 rtl/matrix_led_scanner_if.sv | 24 ++
 rtl/matrix_frame_buffer.sv | 63 ++++++
 rtl/matrix_led_scanner.sv | 153 +++++++++++++++
 tb/tb_matrix_led_scanner.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/matrix_led_pkg.sv
// Shared types and helpers for the LED matrix scanner.
// Holds the scan-state encoding and the output-polarity helper.
package matrix_led_pkg;

  localparam logic [0:0] ST_BLANK = 1'b0;
  localparam logic [0:0] ST_ON    = 1'b1;

  typedef enum logic [0:0] {
    BLANK = ST_BLANK,
    ON    = ST_ON
  } scan_state_t;

  // Physical pin level for a logical "active" flag under the given polarity.
  function automatic logic drive_level(input logic active, input logic active_high);
    return active ^ ~active_high;
  endfunction

endpackage

// File: rtl/matrix_led_scanner_if.sv
// Write/swap bus between a frame producer (master) and the scanner (slave).
interface matrix_led_scanner_if #(
  parameter int ROWS = 8,
  parameter int COLS = 8
);
  localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;

  logic             wr_valid;
  logic             wr_ready;
  logic [COL_W-1:0] wr_col;
  logic [ROWS-1:0]  wr_data;
  logic             swap_req;
  logic             swap_ack;

  modport master (
    output wr_valid, wr_col, wr_data, swap_req,
    input  wr_ready, swap_ack
  );

  modport slave (
    input  wr_valid, wr_col, wr_data, swap_req,
    output wr_ready, swap_ack
  );
endinterface

// File: rtl/matrix_frame_buffer.sv
// Double-buffered pixel store: writes go to the back buffer, the scanner reads
// one row of the front buffer, and a pending swap commits on the frame wrap.
module matrix_frame_buffer
  import matrix_led_pkg::*;
#(
  parameter int ROWS = 8,
  parameter int COLS = 8,
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  matrix_led_scanner_if.slave  bus,
  input  logic                 wrap_i,
  input  logic [RW-1:0]        rd_row_i,
  output logic [COLS-1:0]      rd_cols_o
);

  logic [ROWS-1:0] mem_q [2][COLS];
  logic            front_q, front_d;
  logic            pending_q, pending_d;
  logic            swap_ack_q;
  logic            wr_en;
  logic            commit;

  // A request that lands on the wrap edge itself only arms the flag.
  always_comb begin
    wr_en     = bus.wr_valid && bus.wr_ready && (int'(bus.wr_col) < COLS);
    commit    = wrap_i && pending_q;
    front_d   = front_q ^ commit;
    pending_d = commit ? 1'b0 : (pending_q || bus.swap_req);
  end

  assign bus.wr_ready = ~pending_q;
  assign bus.swap_ack = swap_ack_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < 2; b++) begin
        for (int c = 0; c < COLS; c++) begin
          mem_q[b][c] <= '0;
        end
      end
      front_q    <= 1'b0;
      pending_q  <= 1'b0;
      swap_ack_q <= 1'b0;
    end else begin
      if (wr_en) begin
        mem_q[~front_q][bus.wr_col] <= bus.wr_data;
      end
      front_q    <= front_d;
      pending_q  <= pending_d;
      swap_ack_q <= commit;
    end
  end

  always_comb begin
    rd_cols_o = '0;
    for (int c = 0; c < COLS; c++) begin
      rd_cols_o[c] = mem_q[front_q][c][rd_row_i];
    end
  end

endmodule

// File: rtl/matrix_led_scanner.sv
// Row-multiplexed LED matrix driver: per-row BLANK/ON slots with global PWM
// brightness, registered pin outputs and a double-buffered frame store.
module matrix_led_scanner
  import matrix_led_pkg::*;
#(
  parameter int ROWS                = 8,
  parameter int COLS                = 8,
  parameter int SCAN_DIV            = 27000,
  parameter int BLANK_CYCLES        = 16,
  parameter int PWM_BITS            = 3,
  parameter bit ANODE_ACTIVE_HIGH   = 1'b1,
  parameter bit CATHODE_ACTIVE_HIGH = 1'b0
) (
  input  logic                clk,
  input  logic                rst_n,
  matrix_led_scanner_if.slave bus,
  input  logic [PWM_BITS-1:0] brightness,
  output logic [ROWS-1:0]     row_out,
  output logic [COLS-1:0]     col_out,
  output logic                frame_start
);

  localparam int ON_LEN = SCAN_DIV - BLANK_CYCLES;
  localparam int NSUB   = 2 ** PWM_BITS;
  localparam int SUB    = ON_LEN / NSUB;
  localparam int CNT_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int RW     = (ROWS > 1) ? $clog2(ROWS) : 1;

  localparam logic [CNT_W-1:0]    BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0]    ON_LAST    = CNT_W'(ON_LEN - 1);
  localparam logic [CNT_W-1:0]    SUB_LAST   = CNT_W'(SUB - 1);
  localparam logic [RW-1:0]       ROW_LAST   = RW'(ROWS - 1);
  localparam logic [PWM_BITS-1:0] SUB_MAX    = '1;
  localparam logic [ROWS-1:0]     ROW_IDLE   = {ROWS{~CATHODE_ACTIVE_HIGH}};
  localparam logic [COLS-1:0]     COL_IDLE   = {COLS{~ANODE_ACTIVE_HIGH}};

  if ((SCAN_DIV - BLANK_CYCLES) < (2 ** PWM_BITS) || BLANK_CYCLES < 1) begin : g_bad_params
    $fatal(1, "matrix_led_scanner: ON phase shorter than PWM subslot count or no blanking");
  end

  scan_state_t           state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [CNT_W-1:0]      sub_cnt_q, sub_cnt_d;
  logic [PWM_BITS-1:0]   sub_q, sub_d;
  logic [RW-1:0]         row_q, row_d;
  logic [PWM_BITS-1:0]   bright_q, bright_d;
  logic [ROWS-1:0]       row_out_q, row_out_d;
  logic [COLS-1:0]       col_out_q, col_out_d;
  logic                  frame_q;
  logic                  wrap;
  logic                  lit;
  logic [COLS-1:0]       front_cols;

  matrix_frame_buffer #(
    .ROWS (ROWS),
    .COLS (COLS)
  ) u_frame_buffer (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .wrap_i    (wrap),
    .rd_row_i  (row_q),
    .rd_cols_o (front_cols)
  );

  // The last subslot keeps counting through the division remainder.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sub_cnt_d = sub_cnt_q;
    sub_d     = sub_q;
    row_d     = row_q;
    bright_d  = bright_q;
    wrap      = 1'b0;
    if (state_q == BLANK && cnt_q == '0) begin
      bright_d = brightness;
    end
    case (state_q)
      BLANK: begin
        if (cnt_q == BLANK_LAST) begin
          state_d   = ON;
          cnt_d     = '0;
          sub_cnt_d = '0;
          sub_d     = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ON: begin
        if (cnt_q == ON_LAST) begin
          state_d = BLANK;
          cnt_d   = '0;
          if (row_q == ROW_LAST) begin
            row_d = '0;
            wrap  = 1'b1;
          end else begin
            row_d = row_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (sub_cnt_q == SUB_LAST && sub_q != SUB_MAX) begin
            sub_d     = sub_q + 1'b1;
            sub_cnt_d = '0;
          end else begin
            sub_cnt_d = sub_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = BLANK;
    endcase
  end

  always_comb begin
    lit       = (state_q == ON) && (sub_q < bright_q);
    row_out_d = ROW_IDLE;
    col_out_d = COL_IDLE;
    for (int r = 0; r < ROWS; r++) begin
      row_out_d[r] = drive_level(lit && (row_q == RW'(r)), CATHODE_ACTIVE_HIGH);
    end
    for (int c = 0; c < COLS; c++) begin
      col_out_d[c] = drive_level(lit && front_cols[c], ANODE_ACTIVE_HIGH);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= BLANK;
      cnt_q     <= '0;
      sub_cnt_q <= '0;
      sub_q     <= '0;
      row_q     <= '0;
      bright_q  <= '0;
      row_out_q <= ROW_IDLE;
      col_out_q <= COL_IDLE;
      frame_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sub_cnt_q <= sub_cnt_d;
      sub_q     <= sub_d;
      row_q     <= row_d;
      bright_q  <= bright_d;
      row_out_q <= row_out_d;
      col_out_q <= col_out_d;
      frame_q   <= wrap;
    end
  end

  assign row_out     = row_out_q;
  assign col_out     = col_out_q;
  assign frame_start = frame_q;

endmodule

// File: tb/tb_matrix_led_scanner.sv
// Bench for matrix_led_scanner: cycle-level reference model checked every cycle,
// a brightness table, and directed swap/reset/out-of-range sequences.
module tb_matrix_led_scanner;

  localparam int ROWS = 4, COLS = 4, SD = 20, BL = 4, PB = 2, NSUB = 4, SUB = 4;
  localparam bit AAH = 1'b1, CAH = 1'b0;
  localparam logic [ROWS-1:0] ROW_IDLE = 4'b1111;
  localparam logic [COLS-1:0] COL_IDLE = 4'b0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [PB-1:0] brightness = '0;
  logic [ROWS-1:0] row_out;
  logic [COLS-1:0] col_out;
  logic frame_start;

  logic rst2_n = 1'b0;
  logic [PB-1:0] brightness2 = '0;
  logic [3:0] row_out2;
  logic [2:0] col_out2;
  logic frame_start2;

  matrix_led_scanner_if #(.ROWS(ROWS), .COLS(COLS)) bus ();
  matrix_led_scanner_if #(.ROWS(4), .COLS(3)) bus2 ();

  matrix_led_scanner #(
    .ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SD), .BLANK_CYCLES(BL), .PWM_BITS(PB),
    .ANODE_ACTIVE_HIGH(AAH), .CATHODE_ACTIVE_HIGH(CAH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .brightness(brightness),
    .row_out(row_out), .col_out(col_out), .frame_start(frame_start)
  );

  matrix_led_scanner #(
    .ROWS(4), .COLS(3), .SCAN_DIV(SD), .BLANK_CYCLES(BL), .PWM_BITS(PB),
    .ANODE_ACTIVE_HIGH(1'b1), .CATHODE_ACTIVE_HIGH(1'b0)
  ) dut2 (
    .clk(clk), .rst_n(rst2_n), .bus(bus2), .brightness(brightness2),
    .row_out(row_out2), .col_out(col_out2), .frame_start(frame_start2)
  );

  always #5 clk = ~clk;

  int nChecks = 0;
  int nFails = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model: slot position from the cycle count since reset release.
  logic [ROWS-1:0] mBuf [2][COLS];
  int mN = 0, mFront = 0, mPos, mRow, mSub;
  bit mPending = 0, mLit, mWrap;
  logic [PB-1:0] mBright = '0;
  logic [ROWS-1:0] expRow = ROW_IDLE;
  logic [COLS-1:0] expCol = COL_IDLE;
  logic expFs = 1'b0, expAck = 1'b0, expReady = 1'b1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mN = 0; mFront = 0; mPending = 0; mBright = '0;
      for (int b = 0; b < 2; b++)
        for (int c = 0; c < COLS; c++) mBuf[b][c] = '0;
      expRow = ROW_IDLE; expCol = COL_IDLE; expFs = 0; expAck = 0; expReady = 1;
    end else begin
      mPos = mN % SD;
      mRow = (mN / SD) % ROWS;
      if (mPos == 0) mBright = brightness;
      mSub = (mPos - BL) / SUB;
      if (mSub > NSUB - 1) mSub = NSUB - 1;
      mLit = (mPos >= BL) && (mSub < int'(mBright));
      for (int r = 0; r < ROWS; r++) expRow[r] = (mLit && r == mRow) ? CAH : ~CAH;
      for (int c = 0; c < COLS; c++) expCol[c] = (mLit && mBuf[mFront][c][mRow]) ? AAH : ~AAH;
      mWrap = (mPos == SD - 1) && (mRow == ROWS - 1);
      if (bus.wr_valid && !mPending && int'(bus.wr_col) < COLS)
        mBuf[1 - mFront][bus.wr_col] = bus.wr_data;
      expFs = mWrap;
      expAck = mWrap && mPending;
      if (expAck) begin
        mFront = 1 - mFront;
        mPending = 0;
      end else if (bus.swap_req) begin
        mPending = 1;
      end
      expReady = !mPending;
      mN++;
    end
  end

  always @(negedge clk) begin
    checkOutput("model_row_out", row_out, expRow);
    checkOutput("model_col_out", col_out, expCol);
    checkOutput("model_frame_start", frame_start, expFs);
    checkOutput("model_swap_ack", bus.swap_ack, expAck);
    checkOutput("model_wr_ready", bus.wr_ready, expReady);
  end

  task automatic applyStimulus(input bit v, input logic [1:0] col, input logic [3:0] data,
                               input bit swap, input logic [PB-1:0] br);
    @(negedge clk);
    bus.wr_valid = v; bus.wr_col = col; bus.wr_data = data; bus.swap_req = swap; brightness = br;
  endtask

  task automatic waitSlotStart();
    do @(negedge clk); while (mN % SD != 0);
  endtask

  task automatic waitAck(input int maxCycles, output bit seen);
    seen = 0;
    for (int i = 0; i < maxCycles && !seen; i++) begin
      @(negedge clk);
      if (bus.swap_ack) seen = 1;
    end
  endtask

  task automatic countLit(input int n, input bit useCol, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (useCol ? (col_out != COL_IDLE) : (row_out != ROW_IDLE)) cnt++;
    end
  endtask

  typedef struct {
    logic [PB-1:0] br;
    int            litCycles;
  } vec_t;
  vec_t vecs[4];

  initial begin
    int firstFs, cnt, acks;
    bit seen;
    logic [2:0] exp3;

    vecs[0] = '{br: 2'd0, litCycles: 0};
    vecs[1] = '{br: 2'd1, litCycles: 4};
    vecs[2] = '{br: 2'd2, litCycles: 8};
    vecs[3] = '{br: 2'd3, litCycles: 12};

    bus.wr_valid = 0; bus.wr_col = '0; bus.wr_data = '0; bus.swap_req = 0;
    bus2.wr_valid = 0; bus2.wr_col = '0; bus2.wr_data = '0; bus2.swap_req = 0;

    repeat (3) @(negedge clk);
    checkOutput("rst_wr_ready", bus.wr_ready, 1);
    checkOutput("rst_swap_ack", bus.swap_ack, 0);
    checkOutput("rst_frame_start", frame_start, 0);
    checkOutput("rst_row_out", row_out, ROW_IDLE);
    checkOutput("rst_col_out", col_out, COL_IDLE);
    #2 rst_n = 1;

    // Idle scan: first frame_start on cycle 80.
    firstFs = -1;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (frame_start && firstFs < 0) firstFs = k;
    end
    checkOutput("first_frame_start_cycle", firstFs, 80);

    // Write col2, swap, brightness 3; row 0 lit in subslots 0-2 only.
    applyStimulus(1, 2'd2, 4'b0101, 0, 2'd3);
    applyStimulus(0, 2'd0, 4'b0000, 1, 2'd3);
    applyStimulus(0, 2'd0, 4'b0000, 0, 2'd3);
    waitAck(200, seen);
    checkOutput("swap_ack_seen", seen, 1);
    checkOutput("swap_ack_with_frame_start", frame_start, 1);
    for (int j = 1; j <= SD; j++) begin
      @(negedge clk);
      if (j == 1) checkOutput("wr_ready_after_swap", bus.wr_ready, 1);
      checkOutput($sformatf("row0_col_out_j%0d", j), col_out,
                  (j >= 5 && j <= 16) ? 4'b0100 : 4'b0000);
    end

    // Lit cycles per row slot versus brightness.
    foreach (vecs[i]) begin
      brightness = vecs[i].br;
      waitSlotStart();
      countLit(SD, 0, cnt);
      checkOutput($sformatf("lit_cycles_br%0d", vecs[i].br), cnt, vecs[i].litCycles);
    end

    // Mid-slot brightness change takes effect only at the next slot.
    brightness = 2'd1;
    waitSlotStart();
    cnt = 0;
    for (int j = 1; j <= SD; j++) begin
      @(negedge clk);
      if (j == 8) brightness = 2'd3;
      if (row_out != ROW_IDLE) cnt++;
    end
    checkOutput("midslot_current_lit", cnt, 4);
    countLit(SD, 0, cnt);
    checkOutput("midslot_next_lit", cnt, 12);

    // Double swap_req plus a write while pending.
    applyStimulus(0, 2'd0, 4'b0000, 1, 2'd3);
    applyStimulus(0, 2'd0, 4'b0000, 0, 2'd3);
    applyStimulus(0, 2'd0, 4'b0000, 1, 2'd3);
    applyStimulus(1, 2'd1, 4'b1111, 0, 2'd3);
    checkOutput("wr_ready_while_pending", bus.wr_ready, 0);
    applyStimulus(0, 2'd0, 4'b0000, 0, 2'd3);
    acks = 0; cnt = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.swap_ack) acks++;
      if (acks > 0 && col_out[1] == AAH) cnt++;
    end
    checkOutput("double_swap_ack_count", acks, 1);
    checkOutput("rejected_write_col1_lit", cnt, 0);

    // Swap back: the old buffer kept its contents.
    applyStimulus(0, 2'd0, 4'b0000, 1, 2'd3);
    applyStimulus(0, 2'd0, 4'b0000, 0, 2'd3);
    waitAck(200, seen);
    checkOutput("swap_back_ack", seen, 1);
    cnt = 0;
    for (int j = 1; j <= SD; j++) begin
      @(negedge clk);
      if (col_out == 4'b0100) cnt++;
    end
    checkOutput("kept_back_contents", cnt, 12);

    // Reset mid-ON with a swap pending.
    applyStimulus(0, 2'd0, 4'b0000, 1, 2'd3);
    applyStimulus(0, 2'd0, 4'b0000, 0, 2'd3);
    waitSlotStart();
    repeat (10) @(negedge clk);
    checkOutput("lit_before_reset", row_out != ROW_IDLE, 1);
    #2 rst_n = 0;
    #1;
    checkOutput("reset_row_out_immediate", row_out, ROW_IDLE);
    checkOutput("reset_col_out_immediate", col_out, COL_IDLE);
    repeat (3) @(negedge clk);
    #2 rst_n = 1;
    acks = 0; cnt = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.swap_ack) acks++;
      if (col_out != COL_IDLE) cnt++;
    end
    checkOutput("no_ack_after_reset", acks, 0);
    checkOutput("front_cleared_lit", cnt, 0);
    applyStimulus(0, 2'd0, 4'b0000, 1, 2'd3);
    applyStimulus(0, 2'd0, 4'b0000, 0, 2'd3);
    waitAck(200, seen);
    checkOutput("post_reset_swap_ack", seen, 1);
    countLit(ROWS * SD, 1, cnt);
    checkOutput("back_cleared_lit", cnt, 0);

    // Randomised traffic checked by the model.
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      bus.wr_valid = 1'($urandom_range(0, 1));
      bus.wr_col = 2'($urandom_range(0, 3));
      bus.wr_data = 4'($urandom);
      bus.swap_req = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 29) == 0) brightness = PB'($urandom);
    end
    @(negedge clk);
    bus.wr_valid = 0; bus.swap_req = 0;

    // COLS=3 instance: a write to column 3 is discarded.
    #2 rst2_n = 1;
    @(negedge clk);
    bus2.wr_valid = 1; bus2.wr_col = 2'd3; bus2.wr_data = 4'b1111; brightness2 = 2'd3;
    @(negedge clk);
    bus2.wr_col = 2'd1; bus2.wr_data = 4'b0001;
    @(negedge clk);
    bus2.wr_valid = 0; bus2.swap_req = 1;
    @(negedge clk);
    bus2.swap_req = 0;
    seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (bus2.swap_ack) seen = 1;
    end
    checkOutput("cols3_swap_ack", seen, 1);
    for (int j = 1; j <= 4 * SD; j++) begin
      @(negedge clk);
      exp3 = (j >= 5 && j <= 16) ? 3'b010 : 3'b000;
      checkOutput($sformatf("cols3_col_out_j%0d", j), col_out2, exp3);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "[TB] watchdog");
  end

endmodule
